b_req_ack_responder: RTL and testbench



---
 rtl/hierIncludeB_package.sv | 32 +++
 rtl/b_rsp_accum.sv | 53 +++++
 rtl/b_req_ack_responder.sv | 108 ++++++++++
 tb/tb_b_req_ack_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hierIncludeB_package.sv
// ---------------------------------------------------------------------------
// hierIncludeB_package : B-side request and response types | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hierIncludeB_package;

  localparam int B_ANOTHER_SIZE = 8;
  typedef logic [B_ANOTHER_SIZE-1:0] bSizeT;

  typedef struct packed {
    bSizeT bAnother;
  } bSt;

  localparam int B_RSP_CNT_SIZE = 8;
  typedef logic [B_RSP_CNT_SIZE-1:0] bRspCntT;

  typedef struct packed {
    bSizeT   sum;
    bRspCntT count;
    logic    overflow;
  } bRspSt;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } bRespStateT;

endpackage

`default_nettype wire

// File: rtl/b_rsp_accum.sv
// ---------------------------------------------------------------------------
// b_rsp_accum : sum/count/overflow accumulator with clear and update | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module b_rsp_accum
  import hierIncludeB_package::*;
#(
  parameter int COUNT_SAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      upd,
  input  logic [B_ANOTHER_SIZE-1:0] add_val,
  output logic [$bits(bRspSt)-1:0]  nxt
);

  bRspSt                   r_tot;
  bRspSt                   w_base;
  bRspSt                   w_nxt;
  logic [B_ANOTHER_SIZE:0] w_sum;

  // The next-value view already honours a same-cycle clear, so a transaction
  // accepted together with clr reports totals built from zero.
  always_comb begin
    w_base = clr ? '0 : r_tot;
    w_sum  = {1'b0, w_base.sum} + {1'b0, add_val};
    w_nxt  = '0;
    w_nxt.sum      = w_sum[B_ANOTHER_SIZE-1:0];
    w_nxt.overflow = w_base.overflow | w_sum[B_ANOTHER_SIZE];
    if ((COUNT_SAT != 0) && (&w_base.count)) begin
      w_nxt.count = w_base.count;
    end else begin
      w_nxt.count = w_base.count + 1'b1;
    end
  end

  assign nxt = w_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tot <= '0;
    end else if (clr) begin
      r_tot <= '0;
    end else if (upd) begin
      r_tot <= w_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/b_req_ack_responder.sv
// ---------------------------------------------------------------------------
// b_req_ack_responder : req/ack responder accumulating bSt.bAnother | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module b_req_ack_responder
  import hierIncludeB_package::*;
#(
  parameter int LATENCY   = 3,
  parameter int COUNT_SAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bReq_req,
  input  logic [$bits(bSt)-1:0]    bReq_reqData,
  output logic                     bReq_ack,
  output logic [$bits(bRspSt)-1:0] bReq_ackData,
  input  logic                     clr,
  output logic                     busy,
  output logic                     protoErr
);

  localparam logic [3:0] C_LAT_LOAD = 4'(LATENCY - 1);

  bRespStateT                r_state;
  logic                      r_req_q;
  logic [3:0]                r_cnt;
  bSizeT                     r_data;
  bSt                        w_req;
  bSizeT                     w_add;
  logic                      w_accept;
  logic                      w_clr;
  logic                      w_upd;
  logic [$bits(bRspSt)-1:0]  w_next;

  assign w_req    = bSt'(bReq_reqData);
  assign w_accept = (r_state == IDLE) && bReq_req && !r_req_q;
  assign w_clr    = (r_state == IDLE) && clr;
  assign w_upd    = (r_state == ACK);
  // In IDLE the operand is the live payload so LATENCY=1 can ack next cycle.
  assign w_add    = (r_state == IDLE) ? w_req.bAnother : r_data;

  b_rsp_accum #(
    .COUNT_SAT (COUNT_SAT)
  ) u_accum (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .upd     (w_upd),
    .add_val (w_add),
    .nxt     (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_q      <= 1'b0;
      r_cnt        <= '0;
      r_data       <= '0;
      bReq_ack     <= 1'b0;
      bReq_ackData <= '0;
      busy         <= 1'b0;
      protoErr     <= 1'b0;
    end else begin
      r_req_q      <= bReq_req;
      bReq_ack     <= 1'b0;
      bReq_ackData <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data <= w_req.bAnother;
            r_cnt  <= C_LAT_LOAD;
            busy   <= 1'b1;
            if (LATENCY <= 1) begin
              r_state      <= ACK;
              bReq_ack     <= 1'b1;
              bReq_ackData <= w_next;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!bReq_req) begin
            protoErr <= 1'b1;
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt <= 4'd1) begin
            r_state      <= ACK;
            bReq_ack     <= 1'b1;
            bReq_ackData <= w_next;
          end
        end
        ACK: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_b_req_ack_responder.sv
// ---------------------------------------------------------------------------
// tb_b_req_ack_responder : scoreboard bench, saturating and wrapping builds | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_b_req_ack_responder;
  import hierIncludeB_package::*;

  localparam int LAT = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     req;
  logic                     clr;
  logic [$bits(bSt)-1:0]    req_data;
  logic                     ack_s, ack_w, busy_s, busy_w, perr_s, perr_w;
  logic [$bits(bRspSt)-1:0] ad_s, ad_w;

  b_req_ack_responder #(.LATENCY(LAT), .COUNT_SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .bReq_req(req), .bReq_reqData(req_data),
    .bReq_ack(ack_s), .bReq_ackData(ad_s), .clr(clr), .busy(busy_s), .protoErr(perr_s)
  );

  b_req_ack_responder #(.LATENCY(LAT), .COUNT_SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .bReq_req(req), .bReq_reqData(req_data),
    .bReq_ack(ack_w), .bReq_ackData(ad_w), .clr(clr), .busy(busy_w), .protoErr(perr_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         at;
    logic [7:0] sum;
    logic [7:0] cs;
    logic [7:0] cw;
    logic       ovf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_sum, m_cs, m_cw;
  logic       m_ovf;
  logic [8:0] m_s9;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_zero();
    m_sum = '0; m_cs = '0; m_cw = '0; m_ovf = 1'b0;
  endtask

  // Called in the cycle the rising req is driven; ack is due LAT cycles later.
  task automatic push_model(input logic [7:0] v);
    exp_t e;
    m_s9  = {1'b0, m_sum} + {1'b0, v};
    m_sum = m_s9[7:0];
    m_ovf = m_ovf | m_s9[8];
    m_cs  = (m_cs == 8'hFF) ? 8'hFF : m_cs + 8'd1;
    m_cw  = m_cw + 8'd1;
    e.at = cyc + LAT; e.sum = m_sum; e.cs = m_cs; e.cw = m_cw; e.ovf = m_ovf;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] v, input bit do_clr, input bit drop,
                      input bit clr_busy, input bit hold);
    if (do_clr) model_zero();
    push_model(v);
    req = 1'b1; req_data = v; clr = do_clr;
    tick(1);
    clr = 1'b0;
    chk("busy_accept", {busy_s, busy_w}, 2'b11);
    if (drop) req = 1'b0;
    if (clr_busy) clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("busy_mid", {busy_s, busy_w}, 2'b11);
    tick(1);
    chk("busy_ack", {busy_s, busy_w}, 2'b11);
    tick(1);
    chk("busy_idle", {busy_s, busy_w}, 2'b00);
    if (!hold) begin
      req = 1'b0;
      tick(1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_zero();
    chk("perr_after_rst", {perr_s, perr_w}, 2'b00);
  endtask

  // Monitor: every ack pops one expected response and must land on its cycle.
  bRspSt mon_s, mon_w;
  exp_t  mon_e;
  always @(negedge clk) begin
    if (ack_s || ack_w) begin
      mon_s = bRspSt'(ad_s);
      mon_w = bRspSt'(ad_w);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack %b/%b expected none at cycle %0d", ack_s, ack_w, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_cycle", cyc, mon_e.at);
        chk("ack_both", {ack_s, ack_w}, 2'b11);
        chk("sum_sat", mon_s.sum, mon_e.sum);
        chk("cnt_sat", mon_s.count, mon_e.cs);
        chk("ovf_sat", mon_s.overflow, mon_e.ovf);
        chk("sum_wrap", mon_w.sum, mon_e.sum);
        chk("cnt_wrap", mon_w.count, mon_e.cw);
        chk("ovf_wrap", mon_w.overflow, mon_e.ovf);
      end
    end
  end

  initial begin
    rst = 1'b1; req = 1'b0; clr = 1'b0; req_data = '0;
    model_zero();
    tick(2);
    chk("rst_ack", {ack_s, ack_w}, 2'b00);
    chk("rst_ackdata", ad_s, 0);
    chk("rst_busy", {busy_s, busy_w}, 2'b00);
    chk("rst_perr", {perr_s, perr_w}, 2'b00);
    rst = 1'b0;
    while (cyc < 5) tick(1);

    // First transaction: 0x10 -> {0x10,1,0}, ack at cycle 8.
    send(8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    // Carry out sets overflow, which then stays set.
    send(8'hF5, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    // Held req after ack must not retrigger.
    tick(10);
    req = 1'b0;
    tick(1);
    // clr while BUSY is ignored.
    send(8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    // clr together with the accepting edge: accumulate from zero.
    send(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("perr_clean", {perr_s, perr_w}, 2'b00);

    // req dropped in BUSY: protoErr sticks, ack still on schedule.
    send(8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("perr_set", {perr_s, perr_w}, 2'b11);
    send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("perr_sticky", {perr_s, perr_w}, 2'b11);
    do_reset();

    // Reset mid-transaction drops it; req held through reset is accepted after.
    req = 1'b1; req_data = 8'h33;
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("busy_rst", {busy_s, busy_w}, 2'b00);
    rst = 1'b0;
    model_zero();
    req_data = 8'h44;
    push_model(8'h44);
    tick(4);
    req = 1'b0;
    tick(1);

    // Clear in IDLE, then 256 zero requests: saturate vs wrap on the count.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    model_zero();
    for (int i = 0; i < 256; i++) begin
      send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    tick(6);
    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_ack: got no ack expected one at cycle %0d", mon_e.at);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
